// File: rtl/dmem_store_tracer.sv
// dmem_store_tracer: FWFT FIFO capturing {pc, addr, data} of every dmem store, with sticky overflow and saturating drop counter
// Ports:
//   clock, reset (sync, active-low)
//   enable, pc, dmem_address, dmem_data, dmem_wren  - store capture inputs
//   trace_valid/trace_ready, trace_pc/addr/data      - head-entry read handshake (zeroed when empty)
//   fill_count, overflow, drop_count                 - occupancy and loss status
module dmem_store_tracer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [ADDR_WIDTH-1:0]    dmem_address,
    input  logic [DATA_WIDTH-1:0]    dmem_data,
    input  logic                     dmem_wren,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [DATA_WIDTH-1:0]    trace_pc,
    output logic [ADDR_WIDTH-1:0]    trace_addr,
    output logic [DATA_WIDTH-1:0]    trace_data,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_pc   [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop, full, accept, drop;

    always_comb begin
        push        = enable & dmem_wren;
        trace_valid = fill_count != '0;
        pop         = trace_valid & trace_ready;
        full        = fill_count == (PW+1)'(DEPTH);
        // a pop frees the slot at the same edge, so a full FIFO still accepts
        accept      = push & (~full | pop);
        drop        = push & full & ~pop;
        trace_pc    = trace_valid ? mem_pc[rd_ptr]   : '0;
        trace_addr  = trace_valid ? mem_addr[rd_ptr] : '0;
        trace_data  = trace_valid ? mem_data[rd_ptr] : '0;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_pc[wr_ptr]   <= pc;
            mem_addr[wr_ptr] <= dmem_address;
            mem_data[wr_ptr] <= dmem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept & ~pop) fill_count <= fill_count + 1'b1;
            else if (pop & ~accept) fill_count <= fill_count - 1'b1;
            if (drop) overflow <= 1'b1;
            if (drop && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_store_tracer.sv
// tb_dmem_store_tracer: scoreboard bench for dmem_store_tracer against a queue-based reference model
module tb_dmem_store_tracer;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] p;
        logic [11:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clock = 0;
    logic        reset = 0;
    logic        enable = 0;
    logic [31:0] pc = 0;
    logic [11:0] dmem_address = 0;
    logic [31:0] dmem_data = 0;
    logic        dmem_wren = 0;
    logic        trace_valid;
    logic        trace_ready = 0;
    logic [31:0] trace_pc;
    logic [11:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  fill_count;
    logic        overflow;
    logic [7:0]  drop_count;

    ent_t sb[$];
    int   mfill = 0;
    bit   movf = 0;
    int   mdrop = 0;
    int   tests = 0;
    int   fails = 0;

    dmem_store_tracer #(.DEPTH(DEPTH), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .enable(enable), .pc(pc),
        .dmem_address(dmem_address), .dmem_data(dmem_data), .dmem_wren(dmem_wren),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_addr(trace_addr), .trace_data(trace_data), .fill_count(fill_count),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("fill_count", 96'(fill_count), 96'(mfill));
        chk("overflow", 96'(overflow), 96'(movf));
        chk("drop_count", 96'(drop_count), 96'(mdrop));
        chk("trace_valid", 96'(trace_valid), 96'(mfill != 0));
    endtask

    // monitor: pops the scoreboard on every observed handshake
    always @(negedge clock) begin
        if (reset) begin
            if (trace_valid && trace_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_unexpected: got pc=%0h addr=%0h data=%0h expected no entry",
                             trace_pc, trace_addr, trace_data);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("head_pc", 96'(trace_pc), 96'(e.p));
                    chk("head_addr", 96'(trace_addr), 96'(e.a));
                    chk("head_data", 96'(trace_data), 96'(e.d));
                end
            end else if (!trace_valid) begin
                chk("empty_zero", {trace_pc, trace_addr, trace_data}, 96'd0);
            end
        end
    end

    task automatic step(input bit en, input bit wr, input bit rdy,
                        input logic [31:0] p, input logic [11:0] a, input logic [31:0] d);
        bit popn;
        enable = en; dmem_wren = wr; trace_ready = rdy;
        pc = p; dmem_address = a; dmem_data = d;
        popn = rdy && mfill > 0;
        if (en && wr) begin
            if (mfill < DEPTH || popn) begin
                sb.push_back('{p: p, a: a, d: d});
                mfill++;
            end else begin
                movf = 1;
                if (mdrop < 255) mdrop++;
            end
        end
        if (popn) mfill--;
        @(posedge clock);
        #1;
        check_state();
    endtask

    task automatic store(input logic [31:0] d, input bit rdy);
        step(1, 1, rdy, $urandom, 12'($urandom), d);
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, rdy, $urandom, 12'($urandom), $urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mfill > 0; i++) idle(1);
        chk("drained", 96'(mfill), 96'd0);
    endtask

    task automatic do_reset();
        reset = 0; enable = 1; dmem_wren = 1; trace_ready = 0;
        pc = $urandom; dmem_address = 12'($urandom); dmem_data = $urandom;
        sb.delete();
        mfill = 0; movf = 0; mdrop = 0;
        @(posedge clock);
        #1;
        reset = 1; dmem_wren = 0;
        check_state();
        chk("reset_zero", {trace_pc, trace_addr, trace_data}, 96'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check_state();
        chk("reset_zero", {trace_pc, trace_addr, trace_data}, 96'd0);
        reset = 1;

        // single capture
        step(1, 1, 0, 32'h10, 12'h005, 32'hDEADBEEF);
        chk("cap_pc", 96'(trace_pc), 96'h10);
        chk("cap_addr", 96'(trace_addr), 96'h005);
        chk("cap_data", 96'(trace_data), 96'hDEADBEEF);
        idle(1);
        chk("pop_zero", {trace_pc, trace_addr, trace_data}, 96'd0);

        // fill and overflow
        for (int i = 1; i <= 10; i++) store(i, 0);
        chk("ovf_fill", 96'(fill_count), 96'd8);
        chk("ovf_drops", 96'(drop_count), 96'd2);
        drain();

        // full with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) store(i, 0);
        store(9, 1);
        chk("full_pp_fill", 96'(fill_count), 96'd8);
        chk("full_pp_drops", 96'(drop_count), 96'd0);
        drain();

        // drop saturation then wrap-around
        for (int i = 0; i < 308; i++) store(100 + i, 0);
        chk("sat_drops", 96'(drop_count), 96'd255);
        drain();
        for (int i = 0; i < 20; i++) store(1000 + i, 1);
        drain();

        // enable gating
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, $urandom_range(0, 1), $urandom, 12'($urandom), $urandom);
        chk("gate_fill", 96'(fill_count), 96'd0);

        // reset mid-operation with 5 entries and overflow set
        for (int i = 0; i < 9; i++) store(i, 0);
        for (int i = 0; i < 3; i++) idle(1);
        chk("pre_rst_fill", 96'(fill_count), 96'd5);
        chk("pre_rst_ovf", 96'(overflow), 96'd1);
        do_reset();
        idle(0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
                 $urandom, 12'($urandom), $urandom);
        end
        drain();
        chk("sb_empty", 96'(sb.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_store_tracer.md
# dmem_store_tracer

Debug capture stage that sits directly downstream of the processor's data-memory port in the top-level wrapper. Every cycle in which the processor asserts dmem write enable, it records the current PC, store address, and store data into a small FIFO. A bench or host reads the FIFO through a valid/ready handshake. Overflow is flagged and counted rather than stalling the processor, so the processor timing is never affected.

## Interface
Parameters:
- DEPTH, 8, number of FIFO entries; power of two, at least 2
- ADDR_WIDTH, 12, width of the dmem address captured
- DATA_WIDTH, 32, width of the store data and PC captured

Ports:
- clock  in  1  master clock; the same clock that drives the processor; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- enable  in  1  capture enable; stores are ignored while low
- pc  in  DATA_WIDTH  processor PC of the instruction issuing the store
- dmem_address  in  ADDR_WIDTH  address driven to dmem
- dmem_data  in  DATA_WIDTH  data driven to dmem
- dmem_wren  in  1  dmem write enable
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts the head entry
- trace_pc  out  DATA_WIDTH  head-entry PC
- trace_addr  out  ADDR_WIDTH  head-entry store address
- trace_data  out  DATA_WIDTH  head-entry store data
- fill_count  out  log2(DEPTH)+1  number of occupied entries, 0..DEPTH
- overflow  out  1  sticky flag: at least one store was dropped
- drop_count  out  8  number of dropped stores, saturating at 255

## Operation
- push = enable & dmem_wren. On a push, the entry {pc, dmem_address, dmem_data} is written at the write pointer.
- pop = trace_valid & trace_ready. A pop advances the read pointer.
- The FIFO is first-word-fall-through:
  - trace_valid = (fill_count != 0).
  - trace_pc, trace_addr and trace_data show the head entry whenever trace_valid = 1.
  - These data outputs are forced to 0 whenever trace_valid = 0.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. fill_count is tracked explicitly, not derived from the pointers.
- Full, with no pop in the same cycle:
  - The push is dropped and storage is unchanged.
  - overflow is set to 1.
  - drop_count increments unless it is already 255.
- Full, with a pop in the same cycle: the push is accepted, both pointers advance, and fill_count stays at DEPTH. This is not a drop.
- Empty, with a push: the entry is written and fill_count becomes 1. There is no same-cycle bypass, because a pop is impossible while trace_valid = 0.
- Push and pop in the same cycle when not full and not empty: fill_count is unchanged.
- overflow and drop_count clear only on reset.
- While enable is low:
  - pushes are suppressed;
  - pops continue normally;
  - no drop is counted.

## Timing
- Reset: on a rising edge of clock with reset = 0:
  - read and write pointers = 0; fill_count = 0; overflow = 0; drop_count = 0.
  - trace_valid = 0, so all trace_* data outputs = 0.
- Reset has priority over a simultaneous push or pop. Reset asserted mid-operation discards every stored entry at that edge.
- Capture latency: a store sampled at edge N sets trace_valid and shows its entry starting after edge N (one cycle).
- Pop: with trace_ready high at edge N, the next entry (or trace_valid = 0) is visible after edge N.
- Outputs are combinational from registered state only: no path from trace_ready to trace_valid or to the trace_* data outputs.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Single capture:
  - Stimulus: enable = 1; one cycle of wren = 1 with pc = 0x0000_0010, addr = 0x005, data = 0xDEAD_BEEF; trace_ready = 0.
  - Response: the next cycle shows trace_valid = 1 with exactly those values and fill_count = 1. Raising trace_ready for one cycle gives trace_valid = 0, all data outputs 0, and fill_count = 0.
- Fill and overflow:
  - Stimulus: 10 consecutive stores with data 1..10 and trace_ready = 0.
  - Response: fill_count = 8, overflow = 1, drop_count = 2. Draining returns data 1..8 in order.
- Full with simultaneous push and pop:
  - Stimulus: fill with 1..8, then push data 9 with trace_ready = 1 in the same cycle.
  - Response: fill_count stays 8, drop_count does not change, and the drained order is 2..9.
- Drop saturation and wrap-around:
  - Stimulus: hold the FIFO full and issue 300 further stores.
  - Response: drop_count = 255 (saturated).
  - Stimulus: drain, then run 20 push/pop pairs so the pointers wrap.
  - Response: data comes out in order with no loss.
- Enable gating:
  - Stimulus: enable = 0 with 5 stores.
  - Response: fill_count = 0, overflow = 0, drop_count = 0.
- Reset mid-operation:
  - Stimulus: with 5 entries stored and overflow = 1, hold reset = 0 for one edge while a store is also presented.
  - Response: after that edge, fill_count = 0, trace_valid = 0, overflow = 0, drop_count = 0, and the concurrent store is not captured.
